seq_rr_arb_4_idx: RTL and testbench
===================================

# seq_rr_arb_4_idx

Four-requester round-robin arbiter with a registered valid/ready output carrying the 2-bit index of the granted requester. It sits directly upstream of the 2-to-4 decoder stage: `out_idx` drives the decoder's `in_`, and the decoder's one-hot output is the per-requester grant. A grant is held stable until the consumer accepts it. Priority rotates only on accepted grants.

## Interface

- Parameters: none (requester count fixed at 4, index width fixed at 2).
- `clk`      input   1  clock; all state updates on the rising edge.
- `reset`    input   1  asynchronous, active-low reset.
- `reqs`     input   4  request vector; bit i = requester i wants a grant.
- `out_rdy`  input   1  consumer ready; a handshake occurs on any edge where `out_val` & `out_rdy`.
- `out_val`  output  1  grant valid; registered.
- `out_idx`  output  2  granted requester index, 0..3; registered; meaningful only when `out_val`=1.

## Operation

- State registers:
  - `out_val`.
  - `out_idx`.
  - `ptr`, 2 bits: the highest-priority index.
- Reset (`reset`=0, asynchronous assert): `out_val`=0, `out_idx`=2'b00, `ptr`=2'b00, held for as long as `reset` is low.
- Two states, derived from `out_val`:
  - **EMPTY** (`out_val`=0).
  - **HOLD** (`out_val`=1).
- Load condition: `load` = !`out_val` | (`out_val` & `out_rdy`).
- Effective pointer: `ptr_eff` = handshake ? (`out_idx`+1) mod 4 : `ptr`.
- Arbitration, combinational:
  - Scan `reqs` starting at `ptr_eff`, then increasing index with wrap 3→0.
  - The first set bit wins.
  - If no bit is set, there is no winner.
- At each edge with `load`=1:
  - Winner present: `out_val`←1, `out_idx`←winner.
  - No winner: `out_val`←0, `out_idx` unchanged.
- At each edge with `load`=0 (HOLD, not ready): `out_val`, `out_idx` and `ptr` are unchanged, regardless of `reqs`. This includes the granted requester deasserting its bit; a grant is never revoked.
- Pointer update: on a handshake edge, `ptr`←(`out_idx`+1) mod 4. Otherwise `ptr` is unchanged. A grant that has been issued but not yet accepted does not move the pointer.
- Transitions:
  - EMPTY→HOLD: any request present at an edge.
  - HOLD→HOLD: either `out_rdy`=0, or a handshake with a new winner present.
  - HOLD→EMPTY: a handshake with `reqs`=0.
  - EMPTY→EMPTY: `reqs`=0.
- Index arithmetic is 2-bit modulo-4; 3+1 wraps to 0.

## Timing

- Latency: request sampled at edge N → `out_val`/`out_idx` valid after edge N (1 cycle).
- Throughput: one grant per cycle when `out_rdy` is held high. The next grant loads on the same edge as the handshake.
- Outputs depend only on registers; there is no combinational path from `reqs` or `out_rdy` to any output.
- Sole requester: a single requester held high with `out_rdy`=1 is granted every cycle, because the scan wraps back to it.
- Simultaneous handshake and request change: arbitration uses the `reqs` value sampled at the handshake edge together with `ptr_eff`.
- Reset mid-operation: `out_val` drops to 0 asynchronously and any pending grant is discarded. After deassertion, the first edge arbitrates from `ptr`=0.
- Reset deassertion is assumed synchronised externally to `clk`.

## Structure

- Shared package `ArbPkg`:
  - `localparam NREQS = 4`.
  - `typedef logic [1:0] arb_idx_t`.
  - `typedef logic [3:0] arb_reqs_t`.
- Sub-module `comb_rr_pick_4`, purely combinational:
  - Inputs: `reqs` (4), `ptr` (2).
  - Outputs: `found` (1), `idx` (2).
  - Implements the rotate, priority-encode and un-rotate. It is unit-testable on its own (exhaustive, 64 cases).
- Top level: `load`/`ptr_eff` logic plus the three registers with the async active-low reset.

## Test plan

1. **Reset:** hold `reset`=0 with `reqs`=4'b1111 → `out_val`=0, `out_idx`=0. First edge after release → `out_val`=1, `out_idx`=0.
2. **Rotation:** `reqs`=4'b1111, `out_rdy`=1 for 5 cycles → `out_idx` sequence 0,1,2,3,0, with `out_val`=1 throughout.
3. **Hold under backpressure:** grant idx 2 issued, then `out_rdy`=0 for 3 cycles while `reqs` changes to 4'b0001 → `out_idx` stays 2 and `out_val` stays 1. Raise `out_rdy` → next grant is 0, `ptr`=3.
4. **Skip and wrap:** after accepting idx 3 with `reqs`=4'b0101 → next grants 0,2,0,2.
5. **Drain:** accept the final grant with `reqs`=0 → `out_val`=0 next cycle. Then `reqs`=4'b1000 → `out_val`=1, `out_idx`=3 one cycle later.
6. **Async reset mid-hold:** assert `reset`=0 between edges while `out_val`=1 → `out_val`=0 immediately, without waiting for a clock edge. Release with `reqs`=4'b0110 → `out_idx`=1.

Source files
------------

// File: rtl/seq_rr_arb_4_idx_pkg.sv
// rtl/seq_rr_arb_4_idx_pkg.sv - shared types and helpers for the 4-way round-robin arbiter
//
// Purpose:
//   Common widths, index/request types, the FSM state encoding and the
//   modulo-4 index increment used by the arbiter top and its picker.
// Ports:
//   (package, none)

package ArbPkg;

   // Number of requesters; the index width below is tied to this value.
   localparam int NREQS = 4;

   typedef logic [1:0] arb_idx_t;
   typedef logic [3:0] arb_reqs_t;

   // Output-side state: EMPTY has no grant on the output, HOLD presents one.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } arb_state_t;

   // Next index in round-robin order; 3 wraps to 0 through the 2-bit width.
   function automatic arb_idx_t idx_inc(input arb_idx_t idx);
      return idx + 2'd1;
   endfunction

endpackage : ArbPkg

// File: rtl/seq_rr_arb_4_idx_pick.sv
// rtl/seq_rr_arb_4_idx_pick.sv - combinational rotate / priority-encode / un-rotate picker
//
// Purpose:
//   Finds the first set bit of reqs scanning upward from ptr with wrap 3->0.
// Ports:
//   reqs  in   4  request vector, bit i = requester i
//   ptr   in   2  index with highest priority
//   found out  1  at least one request is set
//   idx   out  2  winning index, valid when found=1 (0 otherwise)

module comb_rr_pick_4
   import ArbPkg::*;
(
   input  logic [3:0] reqs,
   input  logic [1:0] ptr,
   output logic       found,
   output logic [1:0] idx
);

   arb_reqs_t       rot;
   logic      [7:0] dbl;
   arb_idx_t        off;

   always_comb begin
      // Rotate so that requester ptr lands at bit 0; the doubled vector
      // makes the wrap-around a plain part-select.
      dbl = {reqs, reqs};
      rot = dbl[ptr +: 4];

      // Lowest set bit of the rotated vector is the winner's distance from ptr.
      found = 1'b0;
      off   = 2'd0;
      for (int i = NREQS - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            off   = arb_idx_t'(i);
         end
      end

      // Un-rotate: distance back to an absolute index, modulo 4.
      idx = found ? (ptr + off) : 2'd0;
   end

endmodule : comb_rr_pick_4

// File: rtl/seq_rr_arb_4_idx.sv
// rtl/seq_rr_arb_4_idx.sv - 4-requester round-robin arbiter with registered valid/ready index output
//
// Purpose:
//   Issues the index of the granted requester on a registered valid/ready
//   output. A presented grant is held until accepted; priority rotates only
//   when a grant is accepted, and the next grant loads on the accepting edge.
// Ports:
//   clk      in   1  clock, rising edge
//   reset    in   1  asynchronous active-low reset
//   reqs     in   4  request vector
//   out_rdy  in   1  consumer ready
//   out_val  out  1  grant valid (registered)
//   out_idx  out  2  granted index (registered), meaningful when out_val=1

module seq_rr_arb_4_idx
   import ArbPkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] reqs,
   input  logic       out_rdy,
   output logic       out_val,
   output logic [1:0] out_idx
);

   arb_state_t state_q, state_d;
   arb_idx_t   out_idx_q, out_idx_d;
   arb_idx_t   ptr_q, ptr_d;

   logic       hold;
   logic       handshake;
   logic       load;
   arb_idx_t   ptr_eff;
   logic       pick_found;
   arb_idx_t   pick_idx;

   assign hold      = (state_q == ST_HOLD);
   assign handshake = hold & out_rdy;
   assign load      = !hold | handshake;

   // On an accepting edge the register ptr has not yet moved, so arbitrate
   // from the successor of the accepted index directly; this keeps one grant
   // per cycle under continuous ready.
   assign ptr_eff = handshake ? idx_inc(out_idx_q) : ptr_q;

   comb_rr_pick_4 u_pick (
      .reqs  (reqs),
      .ptr   (ptr_eff),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d   = state_q;
      out_idx_d = out_idx_q;
      ptr_d     = ptr_q;

      if (load) begin
         if (pick_found) begin
            state_d   = ST_HOLD;
            out_idx_d = pick_idx;
         end else begin
            // Index is left as-is; it is not meaningful while EMPTY.
            state_d   = ST_EMPTY;
         end
      end

      // Only an accepted grant advances priority.
      if (handshake) begin
         ptr_d = idx_inc(out_idx_q);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_EMPTY;
         out_idx_q <= 2'd0;
         ptr_q     <= 2'd0;
      end else begin
         state_q   <= state_d;
         out_idx_q <= out_idx_d;
         ptr_q     <= ptr_d;
      end
   end

   // Outputs come straight from registers.
   assign out_val = hold;
   assign out_idx = out_idx_q;

endmodule : seq_rr_arb_4_idx

// File: tb/tb_seq_rr_arb_4_idx.sv
// tb/tb_seq_rr_arb_4_idx.sv - self-checking bench for seq_rr_arb_4_idx

module tb_seq_rr_arb_4_idx;

   logic       clk;
   logic       reset;
   logic [3:0] reqs;
   logic       out_rdy;
   logic       out_val;
   logic [1:0] out_idx;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference state: grant valid, granted index, priority pointer.
   int m_val = 0;
   int m_idx = 0;
   int m_ptr = 0;

   seq_rr_arb_4_idx dut (
      .clk     (clk),
      .reset   (reset),
      .reqs    (reqs),
      .out_rdy (out_rdy),
      .out_val (out_val),
      .out_idx (out_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Round-robin reference: scan requesters from the priority start upward,
   // wrapping, and take the first one asking.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_val <= 0;
         m_idx <= 0;
         m_ptr <= 0;
      end else begin
         int  start;
         int  win;
         bit  accepted;
         accepted = (m_val != 0) && out_rdy;
         start    = accepted ? (m_idx + 1) % 4 : m_ptr;
         if (m_val == 0 || accepted) begin
            win = -1;
            for (int k = 0; k < 4; k++) begin
               int j;
               j = (start + k) % 4;
               if (win < 0 && reqs[j]) win = j;
            end
            if (win >= 0) begin
               m_val <= 1;
               m_idx <= win;
            end else begin
               m_val <= 0;
            end
         end
         if (accepted) m_ptr <= (m_idx + 1) % 4;
      end
   end

   // Every falling edge: outputs against the reference.
   always @(negedge clk) begin
      chk("model_val", int'(out_val), m_val);
      if (m_val != 0) chk("model_idx", int'(out_idx), m_idx);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0] r;
      logic       rdy;
   } vec_t;

   vec_t vecs[14];

   initial begin
      vecs[0]  = '{4'b1011, 1'b1};
      vecs[1]  = '{4'b1011, 1'b0};
      vecs[2]  = '{4'b0000, 1'b0};
      vecs[3]  = '{4'b0000, 1'b1};
      vecs[4]  = '{4'b0000, 1'b1};
      vecs[5]  = '{4'b0110, 1'b0};
      vecs[6]  = '{4'b0110, 1'b1};
      vecs[7]  = '{4'b1001, 1'b1};
      vecs[8]  = '{4'b1001, 1'b1};
      vecs[9]  = '{4'b1111, 1'b0};
      vecs[10] = '{4'b1111, 1'b1};
      vecs[11] = '{4'b0010, 1'b1};
      vecs[12] = '{4'b0000, 1'b1};
      vecs[13] = '{4'b1100, 1'b1};

      // Reset held with all requests asserted.
      reset   = 1'b0;
      reqs    = 4'b1111;
      out_rdy = 1'b1;
      step();
      step();
      chk("reset_val", int'(out_val), 0);
      chk("reset_idx", int'(out_idx), 0);
      reset = 1'b1;

      // Rotation 0,1,2,3,0 under continuous ready.
      step();
      chk("rot0_val", int'(out_val), 1);
      chk("rot0_idx", int'(out_idx), 0);
      step(); chk("rot1_idx", int'(out_idx), 1);
      step(); chk("rot2_idx", int'(out_idx), 2);
      step(); chk("rot3_idx", int'(out_idx), 3);
      step(); chk("rot4_idx", int'(out_idx), 0);
      chk("rot4_val", int'(out_val), 1);

      // Grant 2, then backpressure while the requester drops out.
      reqs = 4'b0100;
      step(); chk("bp_grant_idx", int'(out_idx), 2);
      out_rdy = 1'b0;
      reqs    = 4'b0001;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("bp_hold_val", int'(out_val), 1);
         chk("bp_hold_idx", int'(out_idx), 2);
      end
      out_rdy = 1'b1;
      step(); chk("bp_release_idx", int'(out_idx), 0);

      // Accept 3, then alternate between requesters 0 and 2.
      reqs = 4'b1000;
      step(); chk("wrap_pre_idx", int'(out_idx), 3);
      reqs = 4'b0101;
      step(); chk("skip0_idx", int'(out_idx), 0);
      step(); chk("skip1_idx", int'(out_idx), 2);
      step(); chk("skip2_idx", int'(out_idx), 0);
      step(); chk("skip3_idx", int'(out_idx), 2);

      // Drain, then a lone request on 3.
      reqs = 4'b0000;
      step(); chk("drain_val", int'(out_val), 0);
      reqs = 4'b1000;
      step();
      chk("refill_val", int'(out_val), 1);
      chk("refill_idx", int'(out_idx), 3);

      // Drain after accepting 3 leaves the pointer at 0, so 1 beats 3.
      reqs = 4'b0000;
      step(); chk("drain2_val", int'(out_val), 0);
      reqs = 4'b1010;
      step(); chk("ptr_wrap_idx", int'(out_idx), 1);

      // Sole requester granted every cycle.
      reqs = 4'b0100;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("sole_val", int'(out_val), 1);
         chk("sole_idx", int'(out_idx), 2);
      end

      // Asynchronous reset in the middle of a hold.
      out_rdy = 1'b0;
      step();
      chk("pre_areset_val", int'(out_val), 1);
      reset = 1'b0;
      #1;
      chk("areset_val", int'(out_val), 0);
      reqs    = 4'b0110;
      out_rdy = 1'b1;
      step();
      reset = 1'b1;
      step();
      chk("post_areset_val", int'(out_val), 1);
      chk("post_areset_idx", int'(out_idx), 1);

      // Mixed directed vectors, checked against the reference only.
      for (int v = 0; v < 14; v++) begin
         reqs    = vecs[v].r;
         out_rdy = vecs[v].rdy;
         step();
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_seq_rr_arb_4_idx
